// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared state encoding and register constants for the hazard controller
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd3
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk_i) begin
      if (clear) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   input  logic             ex_mem_rd_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             mem_redirect_i,
   input  logic             mem_access_i,
   input  logic             dmem_ready_i,
   output logic             pc_en_o,
   output logic             pc_sel_o,
   output logic             ifid_en_o,
   output logic             idex_en_o,
   output logic             exmem_en_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             exmem_flush_o,
   output logic             memwb_bubble_o,
   output logic             dmem_req_o,
   output logic [1:0]       state_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_e            state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              load_use, mem_stall, flush_inc;

   assign load_use = ex_mem_rd_i && (ex_rd_i != REG_ZERO) &&
                     ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                      (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
   assign mem_stall = mem_access_i && !dmem_ready_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      wait_nxt       = wait_cnt;
      pc_en_o        = 1'b1;
      pc_sel_o       = 1'b0;
      ifid_en_o      = 1'b1;
      idex_en_o      = 1'b1;
      exmem_en_o     = 1'b1;
      ifid_flush_o   = 1'b0;
      idex_flush_o   = 1'b0;
      exmem_flush_o  = 1'b0;
      memwb_bubble_o = 1'b0;
      dmem_req_o     = mem_access_i;
      flush_inc      = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_stall) begin
               pc_en_o        = 1'b0;
               ifid_en_o      = 1'b0;
               idex_en_o      = 1'b0;
               exmem_en_o     = 1'b0;
               memwb_bubble_o = 1'b1;
               state_nxt      = ST_MEM_WAIT;
               wait_nxt       = WAIT_W'(1);
            end else if (mem_redirect_i) begin
               // Redirect also squashes any load-use victim in ID, so no stall is needed
               pc_sel_o      = 1'b1;
               ifid_flush_o  = 1'b1;
               idex_flush_o  = 1'b1;
               exmem_flush_o = 1'b1;
               flush_inc     = 1'b1;
            end else if (load_use) begin
               pc_en_o      = 1'b0;
               ifid_en_o    = 1'b0;
               idex_flush_o = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready_i) begin
               state_nxt = ST_RUN;
               wait_nxt  = '0;
            end else begin
               pc_en_o        = 1'b0;
               ifid_en_o      = 1'b0;
               idex_en_o      = 1'b0;
               exmem_en_o     = 1'b0;
               memwb_bubble_o = 1'b1;
               if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                  state_nxt = ST_ERROR;
               end else begin
                  wait_nxt = wait_cnt + WAIT_W'(1);
               end
            end
         end
         default: begin
            pc_en_o        = 1'b0;
            ifid_en_o      = 1'b0;
            idex_en_o      = 1'b0;
            exmem_en_o     = 1'b0;
            memwb_bubble_o = 1'b1;
            dmem_req_o     = 1'b0;
            state_nxt      = ST_ERROR;
         end
      endcase
   end

   assign state_o = state;
   assign err_o   = (state == ST_ERROR);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .clear (reset_i),
      .inc   (!pc_en_o),
      .cnt   (stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .clear (reset_i),
      .inc   (flush_inc),
      .cnt   (flush_cnt_o)
   );

endmodule
